sc_reconvert_ctrl: RTL and testbench

//  Sequences serial reconversion of one stochastic bitstream back to binary.

---
 rtl/sc_reconvert_ctrl.sv | 143 ++++++++++++++
 tb/tb_sc_reconvert_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_reconvert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sc_reconvert_ctrl
// Description : Serial reconversion of one stochastic bitstream to binary:
//               counts ones over 2**L bits, returns (ones*maxnum) >> L.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_reconvert_ctrl #(
    parameter int LEN_MAX = 8,
    parameter int MAX_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len_log2,
    input  logic [MAX_W-1:0] maxnum,
    input  logic             abort,
    input  logic             sc_bit,
    input  logic             sc_valid,
    output logic             sc_ready,
    output logic             busy,
    output logic [MAX_W-1:0] bnum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cfg_clamped
);

    localparam int         c_cnt_w   = LEN_MAX + 1;
    localparam int         c_prod_w  = LEN_MAX + 1 + MAX_W;
    localparam logic [3:0] c_len_max = 4'(LEN_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [3:0]           r_len;
    logic [MAX_W-1:0]     r_maxnum;
    logic [c_cnt_w-1:0]   r_ones;
    logic [c_cnt_w-1:0]   r_remaining;
    logic                 r_sc_ready;
    logic                 r_busy;
    logic [MAX_W-1:0]     r_bnum;
    logic                 r_out_valid;
    logic                 r_cfg_clamped;

    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_len_over;
    logic [3:0]           w_len_clamp;
    logic [c_prod_w-1:0]  w_prod;

    assign w_start_ok  = (r_state == ST_IDLE) && start && !abort;
    assign w_accept    = (r_state == ST_ACCUM) && r_sc_ready && sc_valid && !abort;
    assign w_last      = w_accept && (r_remaining == c_cnt_w'(1));
    assign w_len_over  = (len_log2 > c_len_max);
    assign w_len_clamp = w_len_over ? c_len_max : len_log2;
    // ones <= 2**LEN_MAX, so the product always fits without loss.
    assign w_prod      = c_prod_w'(r_ones) * c_prod_w'(r_maxnum);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_SCALE;
                end
            end
            ST_SCALE: begin
                w_state_nxt = abort ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (abort || (r_out_valid && out_ready)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sc_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc_ready  <= (w_state_nxt == ST_ACCUM);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len         <= '0;
            r_maxnum      <= '0;
            r_ones        <= '0;
            r_remaining   <= '0;
            r_bnum        <= '0;
            r_cfg_clamped <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len         <= w_len_clamp;
                r_maxnum      <= maxnum;
                r_cfg_clamped <= w_len_over;
                r_ones        <= '0;
                r_remaining   <= c_cnt_w'(1) << w_len_clamp;
            end else if (w_accept) begin
                r_ones        <= r_ones + c_cnt_w'(sc_bit);
                r_remaining   <= r_remaining - c_cnt_w'(1);
            end
            if ((r_state == ST_SCALE) && !abort) begin
                r_bnum <= MAX_W'(w_prod >> r_len);
            end
        end
    end

    assign sc_ready    = r_sc_ready;
    assign busy        = r_busy;
    assign bnum        = r_bnum;
    assign out_valid   = r_out_valid;
    assign cfg_clamped = r_cfg_clamped;

endmodule
`default_nettype wire

// File: tb/tb_sc_reconvert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_reconvert_ctrl
// Description : Scenario bench for sc_reconvert_ctrl with an expected-result
//               queue filled at stimulus time and drained at each output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_reconvert_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len_log2;
    logic [8:0] maxnum;
    logic       abort;
    logic       sc_bit;
    logic       sc_valid;
    logic       sc_ready;
    logic       busy;
    logic [8:0] bnum;
    logic       out_valid;
    logic       out_ready;
    logic       cfg_clamped;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         stim_bits[$];
    logic [8:0] exp_q[$];
    logic [8:0] last_exp = '0;

    sc_reconvert_ctrl #(.LEN_MAX(8), .MAX_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .len_log2(len_log2), .maxnum(maxnum),
        .abort(abort), .sc_bit(sc_bit), .sc_valid(sc_valid), .sc_ready(sc_ready),
        .busy(busy), .bnum(bnum), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_clamped(cfg_clamped)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: count ones in the queued stream, scale and truncate.
    function automatic logic [8:0] model(input logic [3:0] l, input logic [8:0] mx);
        int ones;
        int el;
        ones = 0;
        foreach (stim_bits[i]) ones += int'(stim_bits[i]);
        el = (l > 4'd8) ? 8 : int'(l);
        return 9'((ones * int'(mx)) >> el);
    endfunction

    // Runs one conversion from stim_bits; bstart_cyc >= 0 pulses a stray start then.
    task automatic run_conv(input logic [3:0] l, input logic [8:0] mx, input int gap,
                            input int rdelay, input int bstart_cyc,
                            output logic [8:0] got, output int vcyc, output int taken,
                            output int hold_cnt, output bit unstable, output bit tmo);
        int cyc, idx, extra, gapc, rwait, n;
        bit done;
        logic [8:0] hold_bnum;
        cyc = 0; idx = 0; extra = 0; gapc = 0; rwait = rdelay; done = 0;
        vcyc = -1; hold_cnt = 0; unstable = 0; got = '0; hold_bnum = '0;
        n = stim_bits.size();
        @(negedge clk);
        start = 1'b1; len_log2 = l; maxnum = mx;
        while (!done && cyc < 4000) begin
            if (cyc == bstart_cyc) begin
                start = 1'b1; len_log2 = 4'd0; maxnum = 9'd1;
            end else if (cyc > 0) begin
                start = 1'b0;
            end
            if (gapc > 0) begin
                sc_valid = 1'b0; gapc--;
            end else begin
                sc_valid = 1'b1;
                sc_bit   = (idx < n) ? stim_bits[idx] : 1'b1;
            end
            if (sc_valid && sc_ready) begin
                if (idx < n) idx++; else extra++;
                gapc = gap;
            end
            out_ready = 1'b0;
            if (out_valid) begin
                hold_cnt++;
                if (vcyc < 0) begin
                    vcyc = cyc; hold_bnum = bnum;
                end else if (bnum !== hold_bnum) begin
                    unstable = 1'b1;
                end
                if (rwait > 0) rwait--;
                else begin out_ready = 1'b1; got = bnum; done = 1'b1; end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b0; sc_valid = 1'b0;
        tmo   = !done;
        taken = idx + extra;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; sc_valid = 1'b0; sc_bit = 1'b0;
        out_ready = 1'b0; len_log2 = '0; maxnum = '0;
        @(negedge clk);
        n_checks++; if (sc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sc_ready: got %b expected 0", sc_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (bnum !== 9'd0) begin n_fail++; $display("FAIL rst_bnum: got %0d expected 0", bnum); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (cfg_clamped !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_clamped: got %b expected 0", cfg_clamped); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        stim_bits = '{1, 0, 1, 1, 0, 1, 1, 0};
        exp_q.push_back(model(4'd3, 9'd200));
        run_conv(4'd3, 9'd200, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to) begin n_fail++; $display("FAIL lat_timeout: got no output expected out_valid"); end
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL lat_bnum: got %0d expected %0d", got, exp); end
        n_checks++; if (vc !== 10) begin n_fail++; $display("FAIL lat_cycle: got %0d expected 10", vc); end
        n_checks++; if (tk !== 8) begin n_fail++; $display("FAIL lat_bits: got %0d expected 8", tk); end
        n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL lat_drop: got %b expected 00", {out_valid, busy}); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        stim_bits.delete();
        for (int i = 0; i < 16; i++) stim_bits.push_back(1'b1);
        exp_q.push_back(model(4'd4, 9'd511));
        run_conv(4'd4, 9'd511, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL ones_bnum: got %0d expected %0d", got, exp); end
        n_checks++; if (tk !== 16) begin n_fail++; $display("FAIL ones_bits: got %0d expected 16", tk); end
        for (int i = 0; i < 16; i++) stim_bits[i] = 1'b0;
        exp_q.push_back(model(4'd4, 9'd511));
        run_conv(4'd4, 9'd511, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL zeros_bnum: got %0d expected %0d", got, exp); end
    endtask

    task automatic test_len_zero();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        stim_bits = '{1};
        exp_q.push_back(model(4'd0, 9'd300));
        run_conv(4'd0, 9'd300, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL l0_one_bnum: got %0d expected %0d", got, exp); end
        n_checks++; if (vc !== 3 || tk !== 1) begin n_fail++; $display("FAIL l0_timing: got cyc %0d bits %0d expected cyc 3 bits 1", vc, tk); end
        stim_bits = '{0};
        exp_q.push_back(model(4'd0, 9'd300));
        run_conv(4'd0, 9'd300, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL l0_zero_bnum: got %0d expected %0d", got, exp); end
    endtask

    task automatic test_stall();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        stim_bits = '{1, 1, 0, 1};
        exp_q.push_back(model(4'd2, 9'd100));
        run_conv(4'd2, 9'd100, 3, 5, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL stall_bnum: got %0d expected %0d", got, exp); end
        n_checks++; if (us) begin n_fail++; $display("FAIL stall_stable: got bnum changing expected stable"); end
        n_checks++; if (hc !== 6) begin n_fail++; $display("FAIL stall_hold: got %0d valid cycles expected 6", hc); end
        n_checks++; if (tk !== 4) begin n_fail++; $display("FAIL stall_bits: got %0d expected 4", tk); end
    endtask

    task automatic test_start_while_busy();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        stim_bits = '{1, 1, 1, 1, 0, 0, 0, 0};
        exp_q.push_back(model(4'd3, 9'd200));
        run_conv(4'd3, 9'd200, 0, 0, 3, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL busy_start_bnum: got %0d expected %0d", got, exp); end
        n_checks++; if (tk !== 8 || vc !== 10) begin n_fail++; $display("FAIL busy_start_timing: got bits %0d cyc %0d expected 8 and 10", tk, vc); end
    endtask

    task automatic test_abort();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to, seen;
        @(negedge clk);
        start = 1'b1; len_log2 = 4'd3; maxnum = 9'd400; sc_valid = 1'b1; sc_bit = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++; if (sc_ready !== 1'b1) begin n_fail++; $display("FAIL abort_accum_ready: got %b expected 1", sc_ready); end
        @(negedge clk); @(negedge clk); @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; sc_valid = 1'b0;
        n_checks++; if ({busy, sc_ready, out_valid} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b expected 000", {busy, sc_ready, out_valid}); end
        n_checks++; if (bnum !== last_exp) begin n_fail++; $display("FAIL abort_bnum_kept: got %0d expected %0d", bnum, last_exp); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL abort_no_output: got activity expected idle"); end
        start = 1'b1; abort = 1'b1; len_log2 = 4'd1; maxnum = 9'd10;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_same: got busy %b expected 0", busy); end
        stim_bits = '{1, 0};
        exp_q.push_back(model(4'd1, 9'd10));
        run_conv(4'd1, 9'd10, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL abort_next_bnum: got %0d expected %0d", got, exp); end
    endtask

    task automatic test_clamp();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        stim_bits.delete();
        for (int i = 0; i < 256; i++) stim_bits.push_back(i < 128);
        exp_q.push_back(model(4'd12, 9'd256));
        run_conv(4'd12, 9'd256, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL clamp_bnum: got %0d expected %0d", got, exp); end
        n_checks++; if (tk !== 256 || vc !== 258) begin n_fail++; $display("FAIL clamp_len: got bits %0d cyc %0d expected 256 and 258", tk, vc); end
        n_checks++; if (cfg_clamped !== 1'b1) begin n_fail++; $display("FAIL clamp_flag: got %b expected 1", cfg_clamped); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] got, exp; int vc, tk, hc; bit us, to;
        @(negedge clk);
        start = 1'b1; len_log2 = 4'd9; maxnum = 9'd500; sc_valid = 1'b1; sc_bit = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({busy, sc_ready, cfg_clamped} !== 3'b111) begin n_fail++; $display("FAIL midrst_pre: got %b expected 111", {busy, sc_ready, cfg_clamped}); end
        rst = 1'b1; start = 1'b1; len_log2 = 4'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; sc_valid = 1'b0;
        n_checks++; if ({sc_ready, busy, out_valid, cfg_clamped} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {sc_ready, busy, out_valid, cfg_clamped}); end
        n_checks++; if (bnum !== 9'd0) begin n_fail++; $display("FAIL midrst_bnum: got %0d expected 0", bnum); end
        stim_bits = '{1, 1, 0, 1};
        exp_q.push_back(model(4'd2, 9'd64));
        run_conv(4'd2, 9'd64, 0, 0, -1, got, vc, tk, hc, us, to);
        exp = exp_q.pop_front(); last_exp = exp;
        n_checks++; if (to || got !== exp) begin n_fail++; $display("FAIL midrst_after_bnum: got %0d expected %0d", got, exp); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_len_zero();
        test_stall();
        test_start_while_busy();
        test_abort();
        test_clamp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
